mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between fetch and data requesters
module mem_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;  // 1 = data port was granted last
  logic        gnt_d_r;
  logic [3:0]  cnt;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        we_r;
  logic [3:0]  be_r;
  logic [31:0] i_rdata_r;
  logic [31:0] d_rdata_r;
  logic        grant_d;
  logic        start;
  logic        done;

  // Data wins when alone, or on a tie when fetch was served last.
  assign grant_d = d_req && (!i_req || !last_grant);
  assign start   = (state == IDLE) && (i_req || d_req);
  assign done    = (state == ACCESS) && (cnt == LAT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCESS;
      ACCESS:  if (done)  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      gnt_d_r    <= 1'b0;
      cnt        <= 4'd0;
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
      we_r       <= 1'b0;
      be_r       <= 4'd0;
      i_rdata_r  <= 32'd0;
      d_rdata_r  <= 32'd0;
    end else begin
      state <= state_nxt;
      if (start) begin
        gnt_d_r    <= grant_d;
        last_grant <= grant_d;
        cnt        <= 4'd0;
        addr_r     <= grant_d ? d_addr : i_addr;
        wdata_r    <= grant_d ? d_wdata : 32'd0;
        we_r       <= grant_d && d_we;
        be_r       <= grant_d ? d_be : 4'b1111;
      end
      if (state == ACCESS && !done)
        cnt <= cnt + 4'd1;
      if (done) begin
        if (!gnt_d_r)
          i_rdata_r <= mem_rdata;
        else if (!we_r)
          d_rdata_r <= mem_rdata;
      end
    end
  end

  assign mem_en    = (state == ACCESS) && (cnt == 4'd0);
  assign mem_we    = mem_en && we_r;
  assign mem_be    = mem_en ? be_r : 4'd0;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign i_ack     = (state == RESP) && !gnt_d_r;
  assign d_ack     = (state == RESP) && gnt_d_r;
  assign i_rdata   = i_rdata_r;
  assign d_rdata   = d_rdata_r;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int MEM_LAT = 2;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        busy;
  logic [31:0] rd_addr;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h100) return 32'h00A00093;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory: the address is latched on the issue edge, data stays valid until the next issue.
  always @(posedge clk) if (mem_en) rd_addr <= mem_addr;
  assign mem_rdata = mem_model(rd_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    rd_addr = 0;
    #3;
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, mem_be, i_ack, d_ack, busy, i_rdata, d_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: en=%b we=%b addr=%h be=%h busy=%b i_rdata=%h d_rdata=%h need all 0",
               mem_en, mem_we, mem_addr, mem_be, busy, i_rdata, d_rdata);
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    i_req = 1; i_addr = 32'h100;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL fetch_idle_busy: got %b need 0", busy); end
    step();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_be !== 4'hF) begin
      errors++;
      $display("FAIL fetch_issue: en=%b addr=%h we=%b be=%h need 1 00000100 0 f", mem_en, mem_addr, mem_we, mem_be);
    end
    step();
    checks++;
    if (mem_en !== 1'b0 || mem_addr !== 32'h100) begin
      errors++; $display("FAIL fetch_hold: en=%b addr=%h need 0 00000100", mem_en, mem_addr);
    end
    step();
    checks++;
    if (i_ack !== 1'b0) begin errors++; $display("FAIL fetch_early_ack: got %b need 0", i_ack); end
    step();
    checks++;
    if (i_ack !== 1'b1 || d_ack !== 1'b0 || i_rdata !== 32'h00A00093) begin
      errors++; $display("FAIL fetch_ack: i_ack=%b d_ack=%b i_rdata=%h need 1 0 00a00093", i_ack, d_ack, i_rdata);
    end
    i_req = 0;
    step();
    checks++;
    if (busy !== 1'b0 || i_ack !== 1'b0 || i_rdata !== 32'h00A00093) begin
      errors++; $display("FAIL fetch_after: busy=%b i_ack=%b i_rdata=%h need 0 0 00a00093", busy, i_ack, i_rdata);
    end
  endtask

  task automatic test_tie();
    int n;
    rst = 1; step(); rst = 0;
    i_req = 1; i_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h3000;
    n = 0;
    while (!(i_ack || d_ack) && n < 20) begin step(); n++; end
    checks++;
    if (!(d_ack && !i_ack) || d_rdata !== mem_model(32'h3000)) begin
      errors++; $display("FAIL tie_first: i_ack=%b d_ack=%b d_rdata=%h need d only, %h", i_ack, d_ack, d_rdata, mem_model(32'h3000));
    end
    checks++;
    if (n != MEM_LAT + 2) begin errors++; $display("FAIL tie_latency: got %0d need %0d", n, MEM_LAT + 2); end
    d_req = 0;
    step();
    n = 0;
    while (!(i_ack || d_ack) && n < 20) begin step(); n++; end
    checks++;
    if (!(i_ack && !d_ack) || i_rdata !== mem_model(32'h200)) begin
      errors++; $display("FAIL tie_second: i_ack=%b d_ack=%b i_rdata=%h need i only, %h", i_ack, d_ack, i_rdata, mem_model(32'h200));
    end
    i_req = 0;
    step();
  endtask

  task automatic test_store();
    int ens;
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    step();
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 || mem_addr !== 32'h2000 || mem_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL store_issue: en=%b we=%b be=%b addr=%h wdata=%h need 1 1 0011 00002000 deadbeef",
               mem_en, mem_we, mem_be, mem_addr, mem_wdata);
    end
    d_addr = 32'h9999; d_wdata = 32'h0; d_be = 4'b1100;
    ens = 0;
    for (int k = 0; k < MEM_LAT + 1; k++) begin
      step();
      if (mem_en) ens++;
    end
    checks++;
    if (ens != 0 || mem_addr !== 32'h2000 || mem_wdata !== 32'hDEADBEEF || mem_we !== 1'b0 || mem_be !== 4'b0) begin
      errors++; $display("FAIL store_hold: extra_en=%0d addr=%h wdata=%h we=%b be=%b need 0 00002000 deadbeef 0 0000",
                         ens, mem_addr, mem_wdata, mem_we, mem_be);
    end
    checks++;
    if (d_ack !== 1'b1 || d_rdata !== mem_model(32'h3000)) begin
      errors++; $display("FAIL store_ack: d_ack=%b d_rdata=%h need 1 %h", d_ack, d_rdata, mem_model(32'h3000));
    end
    d_req = 0; d_we = 0;
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    logic exp_d;
    rst = 1; step(); rst = 0;
    i_req = 1; i_addr = 32'h400; d_req = 1; d_we = 0; d_addr = 32'h500;
    for (int k = 0; k < 8; k++) begin
      exp_d = (k % 2 == 0);
      n = 0;
      while (!(i_ack || d_ack) && n < 20) begin step(); n++; end
      checks++;
      if (i_ack === d_ack || d_ack !== exp_d) begin
        errors++; $display("FAIL b2b_order_%0d: i_ack=%b d_ack=%b need d_ack=%b alone", k, i_ack, d_ack, exp_d);
      end
      checks++;
      if ((exp_d ? d_rdata : i_rdata) !== mem_model(exp_d ? 32'h500 : 32'h400)) begin
        errors++; $display("FAIL b2b_data_%0d: got %h need %h", k, exp_d ? d_rdata : i_rdata,
                           mem_model(exp_d ? 32'h500 : 32'h400));
      end
      if (k == 7) begin i_req = 0; d_req = 0; end
      step();
    end
    n = 0;
    while (busy && n < 20) begin step(); n++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain: busy=%b need 0", busy); end
  endtask

  task automatic test_reset_during_access();
    int n;
    int bad;
    i_req = 1; i_addr = 32'h140;
    step();
    checks++;
    if (mem_en !== 1'b1) begin errors++; $display("FAIL rst_pre_issue: en=%b need 1", mem_en); end
    #2 rst = 1;
    #1;
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, mem_be, i_ack, d_ack, busy, i_rdata, d_rdata} !== '0) begin
      errors++;
      $display("FAIL rst_async: en=%b addr=%h busy=%b i_rdata=%h d_rdata=%h need all 0", mem_en, mem_addr, busy, i_rdata, d_rdata);
    end
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (i_ack || d_ack || mem_en) bad++;
    end
    rst = 0;
    checks++;
    if (bad != 0 || i_ack !== 1'b0) begin errors++; $display("FAIL rst_no_ack: got %0d bad cycles need 0", bad); end
    step();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h140) begin
      errors++; $display("FAIL rst_reissue: en=%b addr=%h need 1 00000140", mem_en, mem_addr);
    end
    n = 0;
    while (!(i_ack || d_ack) && n < 20) begin step(); n++; end
    checks++;
    if (i_ack !== 1'b1 || d_ack !== 1'b0 || i_rdata !== mem_model(32'h140) || n != MEM_LAT + 1) begin
      errors++; $display("FAIL rst_reissue_ack: i_ack=%b i_rdata=%h cycles=%0d need 1 %h %0d",
                         i_ack, i_rdata, n, mem_model(32'h140), MEM_LAT + 1);
    end
    i_req = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_tie();
    test_store();
    test_back_to_back();
    test_reset_during_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
